beam_scan_ctrl: RTL and testbench
=================================

Name: beam_scan_ctrl

Overview:
- Steering-scan controller on the consuming end of the delay bank.
- Drives delay_select into the delay bank and takes back its 8 delayed PCM channels.
- Sums the 8 channels into one beam and measures beam energy for each steering direction in turn.
- Reports the highest-energy direction; the summed beam is also streamed out for downstream audio use.

Parameters:
- NUM_DIRS, 4: number of directions scanned; delay_select takes values 0..NUM_DIRS-1 (max 32).
- SETTLE, 32: sample strobes discarded after each delay_select change, to allow delay-line refill.
- DWELL, 256: sample strobes accumulated per direction.
- ACC_W, 48: width of the energy accumulator and of best_energy.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a scan; honoured only in IDLE.
- sample_valid  in  1  one-cycle strobe per PCM sample period.
- delayed_pcm_bus  in  152  8 signed 19-bit channels; channel i occupies bits [19i+18:19i].
- delay_select  out  5  steering index to the delay bank.
- beam_out  out  22  signed sum of the 8 channels.
- beam_valid  out  1  beam_out updated this cycle.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when a scan completes.
- best_dir  out  5  direction with the highest energy.
- best_energy  out  ACC_W  energy of best_dir.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, accumulator and counters cleared.
- Beam path, active in every state:
  - On sample_valid, beam_out takes the sign-extended 22-bit sum of the 8 channels, with no overflow possible.
  - beam_valid is high for the cycle after sample_valid; latency 1 clk.
- Energy per sample: beam_out squared (44-bit unsigned), zero-extended and added to the accumulator.
  - Accumulation happens only in DWELL, on the cycle beam_valid is high, i.e. it uses the registered beam.
  - The accumulator saturates at 2^ACC_W-1 and never wraps.
- IDLE state:
  - On start: dir=0, delay_select=0, counters cleared, go to SETTLE; busy goes high the next cycle.
- SETTLE state:
  - Counts beam_valid strobes; after SETTLE of them, clear the accumulator and go to DWELL.
- DWELL state:
  - Accumulates DWELL strobes, then goes to COMPARE.
- COMPARE state (one clk):
  - If dir==0 or acc > best_energy (strict), then best_energy=acc and best_dir=dir. Ties keep the earlier direction.
  - If dir==NUM_DIRS-1, go to DONE; otherwise dir+1 and delay_select=dir+1 are registered this cycle, then go to SETTLE.
- DONE state (one clk):
  - done=1, then return to IDLE with busy=0 in the IDLE cycle.
  - best_dir and best_energy hold until the next scan's first COMPARE.
- Boundary conditions:
  - start while busy: ignored.
  - sample_valid absent: the FSM stalls in SETTLE/DWELL indefinitely.
  - sample_valid on consecutive clocks: every strobe counted.
  - rst asserted mid-scan: immediate return to IDLE with all outputs 0; the scan restarts only on a new start.
- delay_select in IDLE (macro undefined): 0.

Optional Feature:
- Macro BEAM_SCAN_LOCK_EN.
- Defined: on leaving DONE, delay_select is loaded with best_dir and held through IDLE, so the delay bank stays steered at the winner. A new start still begins the scan from 0.
- Undefined: delay_select returns to 0 on entering IDLE.

Test Plan:
- Bench uses NUM_DIRS=4, SETTLE=2, DWELL=4.
- Sum latency: all channels=1 with one sample_valid -> beam_out=8 and beam_valid exactly 1 clk later; all channels=-262144 -> beam_out=-2097152.
- Direction pick: drive all channels=100 when delay_select==2, otherwise 10 -> done pulse, best_dir=2, best_energy=4*640000=2560000, busy low the following cycle.
- Tie: all channels constant 1 for every direction -> best_dir=0, best_energy=256.
- Saturation: ACC_W=20, all channels=-262144 -> best_energy=1048575, no wrap.
- Robustness: start pulsed mid-DWELL -> scan unaffected. rst low mid-DWELL of dir 1 -> busy, delay_select, best_dir and best_energy are 0 at once, and the scan does not resume without a new start.
- Lock feature: with BEAM_SCAN_LOCK_EN defined and the direction-pick stimulus -> delay_select=2 after done and held; with the macro undefined -> delay_select=0.

Source files
------------

// File: rtl/beam_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : beam_scan_ctrl
//  Description : Steering-scan controller on the consuming end of a delay
//                bank. It steps delay_select through every direction, sums the
//                8 delayed PCM channels into one beam, and accumulates the beam
//                energy for each direction. At the end of the scan it reports
//                the direction with the highest energy. The summed beam is also
//                streamed out in every state for downstream audio use.
//  Optional    : `BEAM_SCAN_LOCK_EN -- when defined, delay_select is loaded
//                with best_dir on leaving DONE and held through IDLE.
//                When undefined, delay_select returns to 0 in IDLE.
//  Ports       : clk, rst (async, active-low)
//                start           - one-cycle scan request, accepted in IDLE
//                sample_valid    - one strobe per PCM sample period
//                delayed_pcm_bus - 8 x signed 19-bit, channel i at [19i+18:19i]
//                delay_select    - steering index to the delay bank
//                beam_out        - signed 22-bit channel sum
//                beam_valid      - beam_out updated this cycle
//                busy / done     - scan in progress / one-cycle completion
//                best_dir        - winning direction
//                best_energy     - energy of best_dir
//  Revision    : 1.0 - initial release
// ============================================================================
module beam_scan_ctrl #(
    parameter int NUM_DIRS = 4,
    parameter int SETTLE   = 32,
    parameter int DWELL    = 256,
    parameter int ACC_W    = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [151:0]     delayed_pcm_bus,
    output logic [4:0]       delay_select,
    output logic [21:0]      beam_out,
    output logic             beam_valid,
    output logic             busy,
    output logic             done,
    output logic [4:0]       best_dir,
    output logic [ACC_W-1:0] best_energy
);

    localparam int c_sq_w     = 44;
    localparam int c_sum_w    = ((ACC_W > c_sq_w) ? ACC_W : c_sq_w) + 1;
    localparam int c_cnt_max  = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last  = c_cnt_w'(DWELL - 1);
    localparam logic [4:0]         c_last_dir    = 5'(NUM_DIRS - 1);
    localparam logic [c_sum_w-1:0] c_acc_max_ext =
        {{(c_sum_w - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_DWELL   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [4:0]           r_dir;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ACC_W-1:0]     r_acc;

    logic                 w_scan_init;
    logic                 w_cnt_inc;
    logic                 w_cnt_clr;
    logic                 w_acc_clr;
    logic                 w_acc_add;
    logic                 w_cmp;
    logic                 w_next_dir;
    logic                 w_leave_done;

    logic [21:0]          w_sum;
    logic [c_sq_w-1:0]    w_beam_ext;
    logic [c_sq_w-1:0]    w_sq;
    logic [c_sum_w-1:0]   w_acc_sum;
    logic [ACC_W-1:0]     w_acc_next;

    // ------------------------------------------------------------------
    // Beam path: 8 x 19-bit signed sum fits in 22 bits, so no overflow.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + {{3{delayed_pcm_bus[19*i+18]}}, delayed_pcm_bus[19*i +: 19]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beam_out   <= '0;
            beam_valid <= 1'b0;
        end else begin
            beam_valid <= sample_valid;
            if (sample_valid) begin
                beam_out <= w_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Energy: square of the registered beam. Sign-extending to 44 bits and
    // multiplying modulo 2^44 gives the exact square because |beam|^2 <= 2^42.
    // The sum is formed one bit wider than either operand so saturation can
    // be detected without wrap for any ACC_W.
    // ------------------------------------------------------------------
    assign w_beam_ext = {{22{beam_out[21]}}, beam_out};
    assign w_sq       = w_beam_ext * w_beam_ext;
    assign w_acc_sum  = {{(c_sum_w - ACC_W){1'b0}}, r_acc}
                      + {{(c_sum_w - c_sq_w){1'b0}}, w_sq};
    assign w_acc_next = (w_acc_sum > c_acc_max_ext) ? {ACC_W{1'b1}}
                                                    : w_acc_sum[ACC_W-1:0];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        w_scan_init  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_acc_clr    = 1'b0;
        w_acc_add    = 1'b0;
        w_cmp        = 1'b0;
        w_next_dir   = 1'b0;
        w_leave_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_scan_init = 1'b1;
                    w_state_nx  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (beam_valid) begin
                    if (r_cnt == c_settle_last) begin
                        w_cnt_clr  = 1'b1;
                        w_acc_clr  = 1'b1;
                        w_state_nx = S_DWELL;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (beam_valid) begin
                    w_acc_add = 1'b1;
                    if (r_cnt == c_dwell_last) begin
                        w_cnt_clr  = 1'b1;
                        w_state_nx = S_COMPARE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                w_cmp = 1'b1;
                if (r_dir == c_last_dir) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_next_dir = 1'b1;
                    w_state_nx = S_SETTLE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_leave_done = 1'b1;
                w_state_nx   = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan datapath: direction, counters, accumulator, best result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir        <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            delay_select <= '0;
            best_dir     <= '0;
            best_energy  <= '0;
        end else begin
            if (w_scan_init) begin
                r_dir        <= '0;
                delay_select <= '0;
                r_cnt        <= '0;
                r_acc        <= '0;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_acc_clr) begin
                r_acc <= '0;
            end else if (w_acc_add) begin
                r_acc <= w_acc_next;
            end

            // Strict compare: ties keep the earlier direction. Direction 0
            // always overwrites so stale results from a prior scan vanish.
            if (w_cmp && ((r_dir == 5'd0) || (r_acc > best_energy))) begin
                best_energy <= r_acc;
                best_dir    <= r_dir;
            end

            if (w_next_dir) begin
                r_dir        <= r_dir + 5'd1;
                delay_select <= r_dir + 5'd1;
            end

            if (w_leave_done) begin
`ifdef BEAM_SCAN_LOCK_EN
                // Park the delay bank on the winning direction.
                delay_select <= best_dir;
`else
                delay_select <= '0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beam_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beam_scan_ctrl
//  Description : Self-checking bench for beam_scan_ctrl (NUM_DIRS=4, SETTLE=2,
//                DWELL=4). A second instance with ACC_W=20 shares all inputs
//                and exposes accumulator saturation. Expected responses are
//                queued when stimulus is issued and popped by monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_scan_ctrl;

    localparam int NUM_DIRS = 4;
    localparam int SETTLE   = 2;
    localparam int DWELL    = 4;

    localparam int M_PICK = 0;
    localparam int M_TIE  = 1;
    localparam int M_SAT  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sample_valid = 1'b0;
    logic [151:0] bus = '0;

    logic [4:0]   delay_select, s_delay_select;
    logic [21:0]  beam_out, s_beam_out;
    logic         beam_valid, s_beam_valid;
    logic         busy, s_busy;
    logic         done, s_done;
    logic [4:0]   best_dir, s_best_dir;
    logic [47:0]  best_energy;
    logic [19:0]  s_best_energy;

    beam_scan_ctrl #(.NUM_DIRS(NUM_DIRS), .SETTLE(SETTLE), .DWELL(DWELL), .ACC_W(48)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .delayed_pcm_bus(bus), .delay_select(delay_select), .beam_out(beam_out),
        .beam_valid(beam_valid), .busy(busy), .done(done), .best_dir(best_dir),
        .best_energy(best_energy)
    );

    beam_scan_ctrl #(.NUM_DIRS(NUM_DIRS), .SETTLE(SETTLE), .DWELL(DWELL), .ACC_W(20)) u_sat (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .delayed_pcm_bus(bus), .delay_select(s_delay_select), .beam_out(s_beam_out),
        .beam_valid(s_beam_valid), .busy(s_busy), .done(s_done), .best_dir(s_best_dir),
        .best_energy(s_best_energy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [4:0]  dir;
        logic [47:0] en;
        logic [19:0] sat_en;
        logic [4:0]  sel;
    } res_t;

    res_t        q_res[$];
    logic [21:0] q_beam[$];
    int          q_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int chan_val(input int mode, input logic [4:0] ds);
        if (mode == M_PICK) return (ds == 5'd2) ? 100 : 10;
        if (mode == M_TIE)  return 1;
        return -262144;
    endfunction

    // Drive one sample strobe with all channels = v; optionally pulse start
    // in the following (gap) cycle.
    task automatic strobe(input int v, input logic [21:0] exp_beam, input logic poke);
        logic [18:0]  c;
        logic [151:0] b;
        @(negedge clk);
        c = 19'(v);
        for (int i = 0; i < 8; i++) b[19*i +: 19] = c;
        bus = b;
        sample_valid = 1'b1;
        q_beam.push_back(exp_beam);
        q_cyc.push_back(cyc + 1);
        @(negedge clk);
        sample_valid = 1'b0;
        start = poke;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_strobe(input int mode, input logic poke);
        int v;
        @(negedge clk);
        v = chan_val(mode, delay_select);
        strobe(v, 22'(8 * v), poke);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic run_scan(input int mode, input int poke_at, input res_t r);
        int d0;
        int n;
        q_res.push_back(r);
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 80) begin
            scan_strobe(mode, (n == poke_at));
            n++;
        end
        if (done_cnt == d0) chk("scan_timeout", 64'd0, 64'd1);
        repeat (4) @(negedge clk);
        chk("delay_select_hold", {59'd0, delay_select}, {59'd0, r.sel});
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    // Beam monitor: every beam_valid must match the oldest queued strobe,
    // including the exact cycle it appears.
    always begin
        @(negedge clk);
        if (beam_valid) begin
            if (q_beam.size() == 0) begin
                chk("unexpected_beam_valid", 64'd1, 64'd0);
            end else begin
                chk("beam_out", {42'd0, beam_out}, {42'd0, q_beam[0]});
                chk("beam_latency", 64'(cyc), 64'(q_cyc[0]));
                void'(q_beam.pop_front());
                void'(q_cyc.pop_front());
            end
        end
    end

    // Result monitor: pops on each done pulse.
    always begin
        res_t r;
        @(negedge clk);
        if (done) begin
            if (q_res.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                r = q_res.pop_front();
                chk("best_dir", {59'd0, best_dir}, {59'd0, r.dir});
                chk("best_energy", {16'd0, best_energy}, {16'd0, r.en});
                chk("sat_best_energy", {44'd0, s_best_energy}, {44'd0, r.sat_en});
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                @(negedge clk);
                chk("done_one_cycle", {63'd0, done}, 64'd0);
                chk("busy_after_done", {63'd0, busy}, 64'd0);
                chk("delay_select_idle", {59'd0, delay_select}, {59'd0, r.sel});
            end
            done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   d0;
        int   n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_delay_select", {59'd0, delay_select}, 64'd0);
        chk("rst_beam_out", {42'd0, beam_out}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_best_energy", {16'd0, best_energy}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Sum latency in IDLE
        strobe(1, 22'd8, 1'b0);
        strobe(-262144, 22'h200000, 1'b0);

        // Direction pick: dir 2 wins; ACC_W=20 copy saturates on dir 2
        r.dir = 5'd2; r.en = 48'd2560000; r.sat_en = 20'd1048575;
`ifdef BEAM_SCAN_LOCK_EN
        r.sel = 5'd2;
`else
        r.sel = 5'd0;
`endif
        run_scan(M_PICK, -1, r);

        // Tie, with a start pulse issued mid-DWELL of direction 1
        r.dir = 5'd0; r.en = 48'd256; r.sat_en = 20'd256; r.sel = 5'd0;
        run_scan(M_TIE, 10, r);

        // Full-scale negative: 4 * 2^42 = 2^44 fits in 48 bits, saturates in 20
        r.dir = 5'd0; r.en = 48'd17592186044416; r.sat_en = 20'd1048575; r.sel = 5'd0;
        run_scan(M_SAT, -1, r);

        // Reset mid-DWELL of direction 1
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (delay_select != 5'd1 && n < 40) begin
            scan_strobe(M_PICK, 1'b0);
            n++;
        end
        chk("reached_dir1", {59'd0, delay_select}, 64'd1);
        repeat (SETTLE + 1) scan_strobe(M_PICK, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_delay_select", {59'd0, delay_select}, 64'd0);
        chk("midrst_best_dir", {59'd0, best_dir}, 64'd0);
        chk("midrst_best_energy", {16'd0, best_energy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) scan_strobe(M_PICK, 1'b0);
        chk("no_resume_busy", {63'd0, busy}, 64'd0);
        chk("no_resume_done", 64'(done_cnt), 64'(d0));
        chk("no_resume_delay_select", {59'd0, delay_select}, 64'd0);

        repeat (4) @(negedge clk);
        chk("beam_queue_drained", 64'(q_beam.size()), 64'd0);
        chk("result_queue_drained", 64'(q_res.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
